// File: rtl/instr_encoder.sv
// Packs a decoded RV64I op into a raw 32-bit instruction word. Unencodable requests are replaced
// by a canonical NOP and counted. Encoded words are buffered in a FIFO drained over valid/ready.
module instr_encoder #(
    parameter int DEPTH = 4,
    parameter int OP_W  = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [OP_W-1:0] req_op,
    input  logic [4:0]      req_rd,
    input  logic [4:0]      req_rs1,
    input  logic [4:0]      req_rs2,
    input  logic [63:0]     req_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic            out_illegal,
    output logic [15:0]     err_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [OP_W-1:0] {
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_LD, OP_SD, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_JAL, OP_JALR, OP_LUI, OP_AUIPC,
        OP_ADDIW, OP_SLLIW, OP_SRLIW, OP_SRAIW, OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW
    } op_e;

    typedef enum logic [3:0] {F_BAD, F_R, F_I, F_SH6, F_SH5, F_S, F_B, F_U, F_J} fmt_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    fmt_e        w_fmt;
    logic [6:0]  w_opc;
    logic [6:0]  w_f7;
    logic [2:0]  w_f3;
    logic [31:0] w_raw;
    logic        w_legal;
    logic [31:0] w_instr;
    logic        w_illegal;
    logic        w_fit12, w_fit13, w_fit21, w_fit32;
    logic        w_push, w_pop;

    always_comb begin
        w_fmt = F_BAD; w_opc = 7'h00; w_f3 = 3'd0; w_f7 = 7'h00;
        case (req_op)
            OP_ADDI:  begin w_fmt = F_I;   w_opc = 7'h13; w_f3 = 3'd0; end
            OP_SLTI:  begin w_fmt = F_I;   w_opc = 7'h13; w_f3 = 3'd2; end
            OP_SLTIU: begin w_fmt = F_I;   w_opc = 7'h13; w_f3 = 3'd3; end
            OP_XORI:  begin w_fmt = F_I;   w_opc = 7'h13; w_f3 = 3'd4; end
            OP_ORI:   begin w_fmt = F_I;   w_opc = 7'h13; w_f3 = 3'd6; end
            OP_ANDI:  begin w_fmt = F_I;   w_opc = 7'h13; w_f3 = 3'd7; end
            OP_SLLI:  begin w_fmt = F_SH6; w_opc = 7'h13; w_f3 = 3'd1; end
            OP_SRLI:  begin w_fmt = F_SH6; w_opc = 7'h13; w_f3 = 3'd5; end
            OP_SRAI:  begin w_fmt = F_SH6; w_opc = 7'h13; w_f3 = 3'd5; w_f7 = 7'h20; end
            OP_ADD:   begin w_fmt = F_R;   w_opc = 7'h33; w_f3 = 3'd0; end
            OP_SUB:   begin w_fmt = F_R;   w_opc = 7'h33; w_f3 = 3'd0; w_f7 = 7'h20; end
            OP_SLL:   begin w_fmt = F_R;   w_opc = 7'h33; w_f3 = 3'd1; end
            OP_SLT:   begin w_fmt = F_R;   w_opc = 7'h33; w_f3 = 3'd2; end
            OP_SLTU:  begin w_fmt = F_R;   w_opc = 7'h33; w_f3 = 3'd3; end
            OP_XOR:   begin w_fmt = F_R;   w_opc = 7'h33; w_f3 = 3'd4; end
            OP_SRL:   begin w_fmt = F_R;   w_opc = 7'h33; w_f3 = 3'd5; end
            OP_SRA:   begin w_fmt = F_R;   w_opc = 7'h33; w_f3 = 3'd5; w_f7 = 7'h20; end
            OP_OR:    begin w_fmt = F_R;   w_opc = 7'h33; w_f3 = 3'd6; end
            OP_AND:   begin w_fmt = F_R;   w_opc = 7'h33; w_f3 = 3'd7; end
            OP_LD:    begin w_fmt = F_I;   w_opc = 7'h03; w_f3 = 3'd3; end
            OP_SD:    begin w_fmt = F_S;   w_opc = 7'h23; w_f3 = 3'd3; end
            OP_BEQ:   begin w_fmt = F_B;   w_opc = 7'h63; w_f3 = 3'd0; end
            OP_BNE:   begin w_fmt = F_B;   w_opc = 7'h63; w_f3 = 3'd1; end
            OP_BLT:   begin w_fmt = F_B;   w_opc = 7'h63; w_f3 = 3'd4; end
            OP_BGE:   begin w_fmt = F_B;   w_opc = 7'h63; w_f3 = 3'd5; end
            OP_BLTU:  begin w_fmt = F_B;   w_opc = 7'h63; w_f3 = 3'd6; end
            OP_BGEU:  begin w_fmt = F_B;   w_opc = 7'h63; w_f3 = 3'd7; end
            OP_JAL:   begin w_fmt = F_J;   w_opc = 7'h6F; end
            OP_JALR:  begin w_fmt = F_I;   w_opc = 7'h67; w_f3 = 3'd0; end
            OP_LUI:   begin w_fmt = F_U;   w_opc = 7'h37; end
            OP_AUIPC: begin w_fmt = F_U;   w_opc = 7'h17; end
            OP_ADDIW: begin w_fmt = F_I;   w_opc = 7'h1B; w_f3 = 3'd0; end
            OP_SLLIW: begin w_fmt = F_SH5; w_opc = 7'h1B; w_f3 = 3'd1; end
            OP_SRLIW: begin w_fmt = F_SH5; w_opc = 7'h1B; w_f3 = 3'd5; end
            OP_SRAIW: begin w_fmt = F_SH5; w_opc = 7'h1B; w_f3 = 3'd5; w_f7 = 7'h20; end
            OP_ADDW:  begin w_fmt = F_R;   w_opc = 7'h3B; w_f3 = 3'd0; end
            OP_SUBW:  begin w_fmt = F_R;   w_opc = 7'h3B; w_f3 = 3'd0; w_f7 = 7'h20; end
            OP_SLLW:  begin w_fmt = F_R;   w_opc = 7'h3B; w_f3 = 3'd1; end
            OP_SRLW:  begin w_fmt = F_R;   w_opc = 7'h3B; w_f3 = 3'd5; end
            OP_SRAW:  begin w_fmt = F_R;   w_opc = 7'h3B; w_f3 = 3'd5; w_f7 = 7'h20; end
            default:  begin w_fmt = F_BAD; end
        endcase
    end

    // A signed immediate fits N bits when every bit above N-1 replicates the sign bit.
    assign w_fit12 = (req_imm[63:11] == '0) || (req_imm[63:11] == '1);
    assign w_fit13 = (req_imm[63:12] == '0) || (req_imm[63:12] == '1);
    assign w_fit21 = (req_imm[63:20] == '0) || (req_imm[63:20] == '1);
    assign w_fit32 = (req_imm[63:31] == '0) || (req_imm[63:31] == '1);

    always_comb begin
        w_raw   = 32'h0;
        w_legal = 1'b0;
        case (w_fmt)
            F_R: begin
                w_raw   = {w_f7, req_rs2, req_rs1, w_f3, req_rd, w_opc};
                w_legal = 1'b1;
            end
            F_I: begin
                w_raw   = {req_imm[11:0], req_rs1, w_f3, req_rd, w_opc};
                w_legal = w_fit12;
            end
            F_SH6: begin
                w_raw   = {w_f7[6:1], req_imm[5:0], req_rs1, w_f3, req_rd, w_opc};
                w_legal = (req_imm[63:6] == '0);
            end
            F_SH5: begin
                w_raw   = {w_f7, req_imm[4:0], req_rs1, w_f3, req_rd, w_opc};
                w_legal = (req_imm[63:5] == '0);
            end
            F_S: begin
                w_raw   = {req_imm[11:5], req_rs2, req_rs1, w_f3, req_imm[4:0], w_opc};
                w_legal = w_fit12;
            end
            F_B: begin
                w_raw   = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, w_f3,
                           req_imm[4:1], req_imm[11], w_opc};
                w_legal = w_fit13 && !req_imm[0];
            end
            F_U: begin
                w_raw   = {req_imm[31:12], req_rd, w_opc};
                w_legal = w_fit32 && (req_imm[11:0] == 12'h000);
            end
            F_J: begin
                w_raw   = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, w_opc};
                w_legal = w_fit21 && !req_imm[0];
            end
            default: begin
                w_raw   = 32'h0;
                w_legal = 1'b0;
            end
        endcase
        w_instr   = w_legal ? w_raw : NOP;
        w_illegal = !w_legal;
    end

    // FIFO stage: a request in a flush cycle is dropped and does not count as an error.
    logic [32:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wp, r_rp;
    logic [PW:0]   r_cnt;
    logic [15:0]   r_err;

    assign req_ready = (r_cnt != CNT_FULL);
    assign out_valid = (r_cnt != '0);
    assign w_push    = req_valid && req_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= {w_illegal, w_instr};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_err <= 16'h0;
        end else if (flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            if (w_push && w_illegal) r_err <= sat_inc(r_err);
        end
    end

    assign out_instr   = out_valid ? r_mem[r_rp][31:0] : 32'h0;
    assign out_illegal = out_valid ? r_mem[r_rp][32] : 1'b0;
    assign err_cnt     = r_err;

endmodule
